multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 43 ++++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcode/funct
// encodings, ALUOp selectors and alucontrol codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_LOGIC = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // bne/andi/ori only decode when the extended opcode set is built in.
  function automatic logic is_legal_op(input logic [5:0] op, input logic ext);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      OP_BNE, OP_ANDI, OP_ORI:                       return ext;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct/opcode to the ALU control code; flags R-type functs
// the ALU does not implement.
module alu_decoder
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  aluop_t                i_aluop,
  input  logic [5:0]            i_funct,
  input  logic [5:0]            i_opcode,
  output logic [ALU_CTRL_W-1:0] o_alucontrol,
  output logic                  o_funct_illegal
);

  logic [2:0] w_code;

  always_comb begin
    w_code          = ALUC_ADD;
    o_funct_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: w_code = ALUC_ADD;
      ALUOP_SUB: w_code = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  w_code = ALUC_ADD;
          FN_SUB:  w_code = ALUC_SUB;
          FN_AND:  w_code = ALUC_AND;
          FN_OR:   w_code = ALUC_OR;
          FN_SLT:  w_code = ALUC_SLT;
          default: begin
            w_code          = ALUC_ADD;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      ALUOP_LOGIC: w_code = (i_opcode == OP_ORI) ? ALUC_OR : ALUC_AND;
      default:     w_code = ALUC_ADD;
    endcase
  end

  assign o_alucontrol = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register and next-state logic, with Moore
// outputs gated by mem_ready, the zero flag and opcode/funct decode.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W    = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXT_OPS       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic                  ImmZext,
  output logic                  PCEn,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALU_CTRL_W-1:0] alucontrol,
  output logic                  illegal_op,
  output logic                  instr_done
);

  localparam logic LP_EXT = (EXT_OPS != 0);

  state_t r_state;
  logic   r_funct_bad;
  logic   w_mem_rdy;
  logic   w_funct_illegal;
  aluop_t w_aluop;

  assign w_mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_funct_bad <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (w_mem_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= S_FETCH;
          if (is_legal_op(opcode, LP_EXT)) begin
            case (opcode)
              OP_LW, OP_SW:             r_state <= S_MEMADR;
              OP_RTYPE:                 r_state <= S_EXEC;
              OP_BEQ, OP_BNE:           r_state <= S_BRANCH;
              OP_ADDI, OP_ANDI, OP_ORI: r_state <= S_IMMEX;
              OP_J:                     r_state <= S_JUMP;
              default:                  r_state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (w_mem_rdy) r_state <= S_MEMWB;
        S_MEMWR:  if (w_mem_rdy) r_state <= S_FETCH;
        // Remember a bad funct so the write-back cycle can drop the register write.
        S_EXEC: begin
          r_state     <= S_ALUWB;
          r_funct_bad <= w_funct_illegal;
        end
        S_IMMEX:  r_state <= S_IMMWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_aluop = ALUOP_ADD;
    case (r_state)
      S_EXEC:   w_aluop = ALUOP_FUNCT;
      S_BRANCH: w_aluop = ALUOP_SUB;
      S_IMMEX:  w_aluop = (opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_LOGIC;
      default:  w_aluop = ALUOP_ADD;
    endcase
  end

  alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .i_aluop        (w_aluop),
    .i_funct        (funct),
    .i_opcode       (opcode),
    .o_alucontrol   (alucontrol),
    .o_funct_illegal(w_funct_illegal)
  );

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ImmZext    = 1'b0;
    PCEn       = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = w_mem_rdy;
        PCEn    = w_mem_rdy;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !is_legal_op(opcode, LP_EXT);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = w_mem_rdy;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        illegal_op = w_funct_illegal;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = !r_funct_bad;
        instr_done = !r_funct_bad;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSrc      = 2'b01;
        PCEn       = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ImmZext = (opcode != OP_ADDI);
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCEn       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides every strobe so an abandoned instruction never commits.
    if (reset) begin
      IRWrite    = 1'b0;
      PCEn       = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model queues
// the expected outputs of every cycle and a monitor compares them on the falling edge.
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] JMP = 6'b000010;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, immzext, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic       illegal, done;
  } outs_t;

  typedef struct {
    outs_t v;
    bit    so;
    int    d;
    string nm;
  } exp_t;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       iord[2], memwrite[2], irwrite[2], regdst[2], memtoreg[2], regwrite[2];
  logic       alusrca[2], immzext[2], pcen[2], illegal[2], done[2];
  logic [1:0] alusrcb[2], pcsrc[2];
  logic [2:0] aluc[2];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_controller u_dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(iord[0]), .MemWrite(memwrite[0]), .IRWrite(irwrite[0]), .RegDst(regdst[0]),
    .MemtoReg(memtoreg[0]), .RegWrite(regwrite[0]), .ALUSrcA(alusrca[0]), .ImmZext(immzext[0]),
    .PCEn(pcen[0]), .ALUSrcB(alusrcb[0]), .PCSrc(pcsrc[0]), .alucontrol(aluc[0]),
    .illegal_op(illegal[0]), .instr_done(done[0])
  );

  multicycle_controller #(.EXT_OPS(0), .MEM_HANDSHAKE(0)) u_dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(iord[1]), .MemWrite(memwrite[1]), .IRWrite(irwrite[1]), .RegDst(regdst[1]),
    .MemtoReg(memtoreg[1]), .RegWrite(regwrite[1]), .ALUSrcA(alusrca[1]), .ImmZext(immzext[1]),
    .PCEn(pcen[1]), .ALUSrcB(alusrcb[1]), .PCSrc(pcsrc[1]), .alucontrol(aluc[1]),
    .illegal_op(illegal[1]), .instr_done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Idle value of every output: all zero, ALU adding.
  function automatic outs_t base();
    outs_t e;
    e      = '0;
    e.aluc = 3'b010;
    return e;
  endfunction

  // {bad, code} for an R-type funct.
  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0_010;
      6'b100010: return 4'b0_110;
      6'b100100: return 4'b0_000;
      6'b100101: return 4'b0_001;
      6'b101010: return 4'b0_111;
      default:   return 4'b1_010;
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 12))
      0: return LW;    1: return SW;    2: return RT;   3: return RT;
      4: return BEQ;   5: return BNE;   6: return ADDI; 7: return ANDI;
      8: return ORI;   9: return JMP;   10: return 6'b111111;
      11: return 6'b000001;
      default: return 6'b010000;
    endcase
  endfunction

  function automatic logic [5:0] rand_fn();
    case ($urandom_range(0, 6))
      0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
      3: return 6'b100101; 4: return 6'b101010; 5: return 6'b000111;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic step(input int d, input bit rst, input bit mr, input bit z,
                      input outs_t e, input bit so, input string nm);
    exp_t x;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    x.v  = e;
    x.so = so;
    x.d  = d;
    x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b1, 1'b1, rb(), base(), 1'b1, "reset");
  endtask

  task automatic do_fetch(input int d, input bit hs, input int nf);
    outs_t e;
    for (int i = 0; i < nf; i++) begin
      e = base(); e.alusrcb = 2'b01;
      step(d, 1'b0, 1'b0, rb(), e, 1'b0, "fetch_wait");
    end
    e = base(); e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
    step(d, 1'b0, hs ? 1'b1 : rb(), rb(), e, 1'b0, "fetch");
  endtask

  // One whole instruction; negative wf/wm/zf pick random wait counts / zero flag.
  task automatic do_instr(input int d, input bit ext, input bit hs, input logic [5:0] op,
                          input logic [5:0] fn, input int wf, input int wm, input int zf);
    outs_t      e;
    int         nf, nm;
    bit         z, lg, bad;
    logic [3:0] fa;
    nf = !hs ? 0 : (wf < 0 ? int'($urandom_range(0, 2)) : wf);
    nm = !hs ? 0 : (wm < 0 ? int'($urandom_range(0, 3)) : wm);
    z  = (zf < 0) ? rb() : zf[0];
    opcode = op;
    funct  = fn;
    do_fetch(d, hs, nf);
    lg = (op inside {LW, SW, RT, BEQ, ADDI, JMP}) || (ext && (op inside {BNE, ANDI, ORI}));
    e = base(); e.alusrcb = 2'b11; e.illegal = !lg;
    step(d, 1'b0, rb(), rb(), e, 1'b0, "decode");
    if (!lg) return;
    case (op)
      LW, SW: begin
        e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(d, 1'b0, rb(), rb(), e, 1'b0, "memadr");
        for (int i = 0; i < nm; i++) begin
          e = base(); e.iord = 1'b1; e.memwrite = (op == SW);
          step(d, 1'b0, 1'b0, rb(), e, 1'b0, "mem_wait");
        end
        e = base(); e.iord = 1'b1; e.memwrite = (op == SW); e.done = (op == SW);
        step(d, 1'b0, hs ? 1'b1 : rb(), rb(), e, 1'b0, "mem_access");
        if (op == LW) begin
          e = base(); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.done = 1'b1;
          step(d, 1'b0, rb(), rb(), e, 1'b0, "memwb");
        end
      end
      RT: begin
        fa  = fn_alu(fn);
        bad = fa[3];
        e = base(); e.alusrca = 1'b1; e.aluc = fa[2:0]; e.illegal = bad;
        step(d, 1'b0, rb(), rb(), e, 1'b0, "exec");
        e = base(); e.regdst = 1'b1; e.regwrite = !bad; e.done = !bad;
        step(d, 1'b0, rb(), rb(), e, 1'b0, "aluwb");
      end
      BEQ, BNE: begin
        e = base(); e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (op == BEQ) ? z : !z; e.done = 1'b1;
        step(d, 1'b0, rb(), z, e, 1'b0, "branch");
      end
      ADDI, ANDI, ORI: begin
        e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.immzext = (op != ADDI);
        e.aluc = (op == ADDI) ? 3'b010 : ((op == ANDI) ? 3'b000 : 3'b001);
        step(d, 1'b0, rb(), rb(), e, 1'b0, "immex");
        e = base(); e.regwrite = 1'b1; e.done = 1'b1;
        step(d, 1'b0, rb(), rb(), e, 1'b0, "immwb");
      end
      default: begin
        e = base(); e.pcsrc = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
        step(d, 1'b0, rb(), rb(), e, 1'b0, "jump");
      end
    endcase
  endtask

  // A load/store cut off by reset while waiting on memory.
  task automatic abandon(input int d, input logic [5:0] op, input int nw);
    outs_t e;
    opcode = op;
    funct  = 6'b100000;
    do_fetch(d, 1'b1, 0);
    e = base(); e.alusrcb = 2'b11;
    step(d, 1'b0, rb(), rb(), e, 1'b0, "decode");
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(d, 1'b0, rb(), rb(), e, 1'b0, "memadr");
    for (int i = 0; i < nw; i++) begin
      e = base(); e.iord = 1'b1; e.memwrite = (op == SW);
      step(d, 1'b0, 1'b0, rb(), e, 1'b0, "mem_wait");
    end
    do_reset(d, 2);
  endtask

  always @(negedge clk) begin
    exp_t                    x;
    outs_t                   g;
    logic [$bits(outs_t)-1:0] m;
    if (q.size() > 0) begin
      x = q.pop_front();
      g = {iord[x.d], memwrite[x.d], irwrite[x.d], regdst[x.d], memtoreg[x.d], regwrite[x.d],
           alusrca[x.d], immzext[x.d], pcen[x.d], alusrcb[x.d], pcsrc[x.d], aluc[x.d],
           illegal[x.d], done[x.d]};
      if (x.so) begin
        m = {2'b01, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1};
      end else begin
        m = '1;
      end
      n_cmp++;
      if ((g & m) !== (x.v & m)) begin
        n_bad++;
        $display("FAIL %s dut%0d @%0t: got %b required %b (mask %b)", x.nm, x.d, $time,
                 g, x.v, m);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clk);
    #1;
    do_reset(0, 2);
    do_instr(0, 1, 1, LW,  6'b100000, 0, 0, -1);
    do_instr(0, 1, 1, SW,  6'b100000, 0, 3, -1);
    do_instr(0, 1, 1, BEQ, 6'b100000, 0, 0, 1);
    do_instr(0, 1, 1, BNE, 6'b100000, 0, 0, 1);
    do_instr(0, 1, 1, BEQ, 6'b100000, 1, 0, 0);
    do_instr(0, 1, 1, BNE, 6'b100000, 2, 0, 0);
    do_instr(0, 1, 1, ORI, 6'b000000, 0, 0, -1);
    do_instr(0, 1, 1, ANDI, 6'b000000, 0, 0, -1);
    do_instr(0, 1, 1, ADDI, 6'b000000, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b100000, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b100010, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b100100, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b100101, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b101010, 0, 0, -1);
    do_instr(0, 1, 1, RT,  6'b000111, 0, 0, -1);
    do_instr(0, 1, 1, 6'b111111, 6'b100000, 0, 0, -1);
    do_instr(0, 1, 1, JMP, 6'b100000, 0, 0, -1);
    do_instr(0, 1, 1, LW,  6'b100000, 2, 3, -1);
    abandon(0, LW, 2);
    do_instr(0, 1, 1, LW,  6'b100000, 0, 1, -1);
    abandon(0, SW, 1);
    do_instr(0, 1, 1, SW,  6'b100000, 0, 0, -1);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) abandon(0, rb() ? LW : SW, int'($urandom_range(0, 2)));
      do_instr(0, 1, 1, rand_op(), rand_fn(), -1, -1, -1);
    end

    do_reset(1, 2);
    do_instr(1, 0, 0, ORI,  6'b000000, 0, 0, -1);
    do_instr(1, 0, 0, ANDI, 6'b000000, 0, 0, -1);
    do_instr(1, 0, 0, BNE,  6'b000000, 0, 0, 1);
    do_instr(1, 0, 0, ADDI, 6'b000000, 0, 0, -1);
    do_instr(1, 0, 0, LW,   6'b100000, 2, 3, -1);
    do_instr(1, 0, 0, SW,   6'b100000, 2, 3, -1);
    do_instr(1, 0, 0, BEQ,  6'b100000, 0, 0, 1);
    for (int i = 0; i < 40; i++) do_instr(1, 0, 0, rand_op(), rand_fn(), -1, -1, -1);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
